hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Eight-digit seven-segment display controller.
// A frame (data, enable mask, leading-zero blanking, blink mask) is latched into
// shadow registers, then a sequencer walks digits 0..7 through one shared
// nibble decoder, writing one digit register every TICK_DIV cycles.
// A free-running blink divider gates the outputs of digits selected for blinking.
module hex_display_ctrl #(
    parameter int TICK_DIV  = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_valid,
    input  logic [31:0] i_wr_data,
    input  logic [7:0]  i_wr_en_mask,
    input  logic        i_wr_lzb,
    input  logic [7:0]  i_wr_blink,
    output logic        o_wr_ready,
    output logic        o_busy,
    output logic [6:0]  o_hex0,
    output logic [6:0]  o_hex1,
    output logic [6:0]  o_hex2,
    output logic [6:0]  o_hex3,
    output logic [6:0]  o_hex4,
    output logic [6:0]  o_hex5,
    output logic [6:0]  o_hex6,
    output logic [6:0]  o_hex7
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    // A one-cycle step still needs a one-bit counter.
    localparam int STEP_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [6:0]         SEG_BLANK  = 7'h7F;

    logic [0:0]         state_reg;
    logic [2:0]         index_reg;
    logic [STEP_W-1:0]  step_reg;
    logic [31:0]        shadow_data_reg;
    logic [7:0]         shadow_mask_reg;
    logic               shadow_lzb_reg;
    logic [7:0]         shadow_blink_reg;
    logic [6:0]         digit_reg [8];
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    logic [7:0] lead_zero;
    logic [3:0] cur_nibble;
    logic [6:0] seg_dec;
    logic       blank_sel;
    logic [6:0] digit_value;
    logic [6:0] hex_out [8];

    // lead_zero[k]: nibbles k..7 of the frame are all zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lead
            assign lead_zero[gi] = ((shadow_data_reg >> (4 * gi)) == 32'd0);
        end
    endgenerate

    assign cur_nibble = shadow_data_reg[index_reg*4 +: 4];

    // The single shared nibble-to-segment decoder (active-low {g,f,e,d,c,b,a}).
    always_comb begin
        seg_dec = SEG_BLANK;
        case (cur_nibble)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = SEG_BLANK;
        endcase
    end

    // Digit 0 is never leading-zero blanked so an all-zero frame still shows "0".
    assign blank_sel   = ~shadow_mask_reg[index_reg] |
                         (shadow_lzb_reg & (index_reg != 3'd0) & lead_zero[index_reg]);
    assign digit_value = blank_sel ? SEG_BLANK : seg_dec;

    // Frame capture and digit scan sequencer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg        <= IDLE;
            index_reg        <= 3'd0;
            step_reg         <= '0;
            shadow_data_reg  <= 32'd0;
            shadow_mask_reg  <= 8'd0;
            shadow_lzb_reg   <= 1'b0;
            shadow_blink_reg <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                digit_reg[i] <= SEG_BLANK;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_wr_valid) begin
                        shadow_data_reg  <= i_wr_data;
                        shadow_mask_reg  <= i_wr_en_mask;
                        shadow_lzb_reg   <= i_wr_lzb;
                        shadow_blink_reg <= i_wr_blink;
                        index_reg        <= 3'd0;
                        step_reg         <= '0;
                        state_reg        <= SCAN;
                    end
                end
                SCAN: begin
                    if (step_reg == STEP_LAST) begin
                        digit_reg[index_reg] <= digit_value;
                        step_reg             <= '0;
                        index_reg            <= index_reg + 3'd1;
                        if (index_reg == 3'd7) begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        step_reg <= step_reg + STEP_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Free-running blink divider, independent of the scan state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_out
            assign hex_out[gi] = (shadow_blink_reg[gi] & blink_phase_reg) ? SEG_BLANK : digit_reg[gi];
        end
    endgenerate

    assign o_wr_ready = (state_reg == IDLE);
    assign o_busy     = (state_reg == SCAN);
    assign o_hex0     = hex_out[0];
    assign o_hex1     = hex_out[1];
    assign o_hex2     = hex_out[2];
    assign o_hex3     = hex_out[3];
    assign o_hex4     = hex_out[4];
    assign o_hex5     = hex_out[5];
    assign o_hex6     = hex_out[6];
    assign o_hex7     = hex_out[7];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: a timing-level model (digit k of a frame lands
// (k+1)*TICK cycles after accept, blink phase = floor(cycles/BLINK) mod 2)
// is compared against the DUT every cycle, plus literal spot checks.
module tb_hex_display_ctrl;

    localparam int TICK  = 4;
    localparam int BLINK = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [7:0]  wr_en_mask;
    logic        wr_lzb;
    logic [7:0]  wr_blink;
    logic        wr_ready;
    logic        busy;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [6:0]  hex [8];

    // Second instance exercising the one-cycle-per-digit configuration.
    logic        v1_valid;
    logic        v1_ready;
    logic        v1_busy;
    logic [6:0]  h1_0, h1_1, h1_2, h1_3, h1_4, h1_5, h1_6, h1_7;

    int n_checks = 0;
    int n_fails  = 0;

    hex_display_ctrl #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .i_wr_en_mask(wr_en_mask), .i_wr_lzb(wr_lzb), .i_wr_blink(wr_blink),
        .o_wr_ready(wr_ready), .o_busy(busy),
        .o_hex0(hex0), .o_hex1(hex1), .o_hex2(hex2), .o_hex3(hex3),
        .o_hex4(hex4), .o_hex5(hex5), .o_hex6(hex6), .o_hex7(hex7)
    );

    hex_display_ctrl #(.TICK_DIV(1), .BLINK_DIV(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(v1_valid), .i_wr_data(32'h89ABCDEF),
        .i_wr_en_mask(8'hFF), .i_wr_lzb(1'b0), .i_wr_blink(8'h00),
        .o_wr_ready(v1_ready), .o_busy(v1_busy),
        .o_hex0(h1_0), .o_hex1(h1_1), .o_hex2(h1_2), .o_hex3(h1_3),
        .o_hex4(h1_4), .o_hex5(h1_5), .o_hex6(h1_6), .o_hex7(h1_7)
    );

    assign hex[0] = hex0; assign hex[1] = hex1; assign hex[2] = hex2; assign hex[3] = hex3;
    assign hex[4] = hex4; assign hex[5] = hex5; assign hex[6] = hex6; assign hex[7] = hex7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [6:0]  m_dig [8];
    logic        m_scan;
    int          m_cyc;
    int          m_acc;
    logic [31:0] m_data;
    logic [7:0]  m_mask;
    logic        m_lzb;
    logic [7:0]  m_blink;

    function automatic logic [6:0] expect_digit(input logic [31:0] d, input logic [7:0] m,
                                                input logic l, input int k);
        logic [31:0] upper;
        upper = d >> (4 * k);
        if (!m[k]) return 7'h7F;
        if (l && k != 0 && upper == 32'd0) return 7'h7F;
        return seg_tab[upper[3:0]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_dig[i] = 7'h7F;
            m_scan  = 1'b0;
            m_cyc   = 0;
            m_acc   = 0;
            m_data  = 32'd0;
            m_mask  = 8'd0;
            m_lzb   = 1'b0;
            m_blink = 8'd0;
        end else begin
            m_cyc++;
            if (m_scan) begin
                int el;
                el = m_cyc - m_acc;
                if (el % TICK == 0) begin
                    m_dig[el / TICK - 1] = expect_digit(m_data, m_mask, m_lzb, el / TICK - 1);
                    if (el / TICK == 8) m_scan = 1'b0;
                end
            end else if (wr_valid) begin
                m_scan  = 1'b1;
                m_acc   = m_cyc;
                m_data  = wr_data;
                m_mask  = wr_en_mask;
                m_lzb   = wr_lzb;
                m_blink = wr_blink;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [57:0] exp_v, act_v;
        logic        phase;
        phase = ((m_cyc / BLINK) % 2) == 1;
        exp_v = {!m_scan, m_scan, 56'd0};
        act_v = {wr_ready, busy, 56'd0};
        for (int k = 0; k < 8; k++) begin
            exp_v[k*7 +: 7] = (m_blink[k] && phase) ? 7'h7F : m_dig[k];
            act_v[k*7 +: 7] = hex[k];
        end
        n_checks++;
        if (act_v !== exp_v) begin
            n_fails++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
    end

    // ---------------- literal checks and stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at accept edge+1 with valid dropped.
    task automatic send(input logic [31:0] d, input logic [7:0] m, input logic l, input logic [7:0] b);
        logic rdy;
        int   t;
        wr_valid = 1'b1; wr_data = d; wr_en_mask = m; wr_lzb = l; wr_blink = b;
        t = 0;
        forever begin
            rdy = wr_ready;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1;
        wr_valid = 1'b0;
    endtask

    function automatic logic [55:0] all_hex();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    initial begin
        int blanks, lits;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_en_mask = '0; wr_lzb = 1'b0;
        wr_blink = '0; v1_valid = 1'b0;
        tick(3);
        chk("reset_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hex", 32'(all_hex() != {8{7'h7F}}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic frame timing.
        send(32'h89ABCDEF, 8'hFF, 1'b0, 8'h00);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        tick(3);
        chk("hex0_before", {25'd0, hex0}, 32'h7F);
        tick(1);
        chk("hex0_at_4", {25'd0, hex0}, 32'h0E);
        chk("hex1_at_4", {25'd0, hex1}, 32'h7F);
        tick(27);
        chk("ready_at_31", {31'd0, wr_ready}, 32'd0);
        tick(1);
        chk("hex7_at_32", {25'd0, hex7}, 32'h00);
        chk("ready_at_32", {31'd0, wr_ready}, 32'd1);
        chk("frame1", 32'(all_hex() != {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}), 32'd0);

        // Leading-zero blanking.
        send(32'h00000A00, 8'hFF, 1'b1, 8'h00);
        tick(32);
        chk("lzb_a00", 32'(all_hex() != {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40}), 32'd0);
        send(32'h00000000, 8'hFF, 1'b1, 8'h00);
        tick(32);
        chk("lzb_zero", 32'(all_hex() != {{7{7'h7F}}, 7'h40}), 32'd0);

        // Enable mask.
        send(32'h12345678, 8'hF0, 1'b0, 8'h00);
        tick(32);
        chk("mask_f0", 32'(all_hex() != {7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F}), 32'd0);

        // Valid held high during a scan with a different frame.
        send(32'h11111111, 8'hFF, 1'b0, 8'h00);
        wr_valid = 1'b1; wr_data = 32'h22222222;
        tick(16);
        chk("hold_no_capture", {25'd0, hex7}, 32'h79);
        tick(16);
        chk("hold_ready_32", {31'd0, wr_ready}, 32'd1);
        chk("hold_first_frame", 32'(all_hex() != {8{7'h79}}), 32'd0);
        send(32'h22222222, 8'hFF, 1'b0, 8'h00);
        chk("hold_second_busy", {31'd0, busy}, 32'd1);
        tick(32);
        chk("hold_second_frame", 32'(all_hex() != {8{7'h24}}), 32'd0);

        // Blink on digit 0 only.
        send(32'h00000001, 8'hFF, 1'b0, 8'h01);
        tick(33);
        blanks = 0; lits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hex0 == 7'h7F) blanks++;
            else if (hex0 == 7'h79) lits++;
            chk("blink_steady_hex1", {25'd0, hex1}, 32'h40);
        end
        chk("blink_blank_count", 32'(blanks), 32'd4);
        chk("blink_lit_count", 32'(lits), 32'd4);
        @(posedge clk); #1;

        // Reset mid-scan.
        send(32'h12345678, 8'hFF, 1'b0, 8'h00);
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hex", 32'(all_hex() != {8{7'h7F}}), 32'd0);
        chk("rst_mid_ready", {31'd0, wr_ready}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("rst_no_stale", 32'(all_hex() != {8{7'h7F}}), 32'd0);
        chk("rst_ready_after", {31'd0, wr_ready}, 32'd1);

        // One digit per cycle configuration.
        v1_valid = 1'b1;
        tick(1);
        v1_valid = 1'b0;
        chk("t1_busy", {31'd0, v1_busy}, 32'd1);
        tick(1);
        chk("t1_hex0_at_1", {25'd0, h1_0}, 32'h0E);
        chk("t1_hex1_at_1", {25'd0, h1_1}, 32'h7F);
        tick(6);
        chk("t1_ready_at_7", {31'd0, v1_ready}, 32'd0);
        tick(1);
        chk("t1_ready_at_8", {31'd0, v1_ready}, 32'd1);
        chk("t1_frame", 32'({h1_7, h1_6, h1_5, h1_4, h1_3, h1_2, h1_1, h1_0} !=
                            {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}), 32'd0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
